// File: rtl/elixirchip_es1_spu_match_stim.sv
// LFSR-driven burst stimulus for the ES1 SPU match op: operands, valid bubbles, clear pulses, drain, done.
// Optional returned-result compare enabled by defining SPU_MATCH_STIM_SELFCHECK_EN.
module elixirchip_es1_spu_match_stim #(
  parameter int unsigned LATENCY        = 1,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned MATCH_RATIO    = 8,
  parameter logic        BUBBLE_EN      = 1'b1,
  parameter int unsigned CLEAR_INTERVAL = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cke,
  input  logic                 start,
  input  logic [15:0]          num_vectors,
  input  logic [31:0]          seed,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] s_data0,
  output logic [DATA_BITS-1:0] s_data1,
  output logic                 s_clear,
  output logic                 s_valid,
  input  logic                 m_data,
  output logic [15:0]          err_count
);

  localparam int unsigned CNT_W     = 16;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [3:0]  DRAIN_LAST = 4'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [CNT_W-1:0] CLR_N = CNT_W'(CLEAR_INTERVAL);
  localparam logic [4:0]  RATIO     = 5'(MATCH_RATIO);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e               state_q, state_d;
  logic [31:0]          lfsr_q, lfsr_d;
  logic [CNT_W-1:0]     num_q, num_d;
  logic [CNT_W-1:0]     issued_q, issued_d;
  logic [CNT_W-1:0]     since_q, since_d;
  logic [3:0]           drain_q, drain_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 valid_q, valid_d;
  logic                 clear_q, clear_d;
  logic [DATA_BITS-1:0] data0_q, data0_d;
  logic [DATA_BITS-1:0] data1_q, data1_d;
  logic                 start_acc_c;

  // Next-state and registered-output decode; data holds whenever no vector is issued.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    num_d       = num_q;
    issued_d    = issued_q;
    since_d     = since_q;
    drain_d     = drain_q;
    valid_d     = 1'b0;
    clear_d     = 1'b0;
    data0_d     = data0_q;
    data1_d     = data1_q;
    start_acc_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc_c = 1'b1;
          num_d       = num_vectors;
          lfsr_d      = (seed == 32'h0) ? 32'h1 : seed;
          issued_d    = '0;
          since_d     = '0;
          state_d     = (num_vectors == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        if ((CLEAR_INTERVAL != 0) && (since_q == CLR_N)) begin
          clear_d = 1'b1;
          since_d = '0;
        end else if (!(BUBBLE_EN && (lfsr_q[1:0] == 2'b00))) begin
          valid_d  = 1'b1;
          data0_d  = lfsr_q[DATA_BITS-1:0];
          // Unforced vectors flip bit 0 so they are guaranteed to mismatch.
          data1_d  = ({1'b0, lfsr_q[7:4]} < RATIO) ? lfsr_q[DATA_BITS-1:0]
                                                   : lfsr_q[DATA_BITS-1:0] ^ DATA_BITS'(1);
          issued_d = issued_q + 16'd1;
          since_d  = since_q + 16'd1;
          if (issued_d == num_q) begin
            state_d = (LATENCY == 0) ? ST_DONE : ST_DRAIN;
            drain_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = ST_DONE;
        else                       drain_d = drain_q + 4'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= 32'h1;
      num_q    <= '0;
      issued_q <= '0;
      since_q  <= '0;
      drain_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      clear_q  <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
    end else if (cke) begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      num_q    <= num_d;
      issued_q <= issued_d;
      since_q  <= since_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      clear_q  <= clear_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign s_valid = valid_q;
  assign s_clear = clear_q;
  assign s_data0 = data0_q;
  assign s_data1 = data1_q;

`ifdef SPU_MATCH_STIM_SELFCHECK_EN
  logic        exp_c, chk_valid_c, chk_clear_c;
  logic [15:0] err_q, err_d;

  if (LATENCY == 0) begin : g_lat0
    assign exp_c       = (data0_q == data1_q);
    assign chk_valid_c = valid_q;
    assign chk_clear_c = clear_q;
  end else begin : g_dly
    // {expect, valid, clear} aligned with the DUT result LATENCY cke cycles later.
    logic [2:0] dly_q [LATENCY];
    logic [2:0] dly_d [LATENCY];

    always_comb begin
      dly_d[0] = {data0_q == data1_q, valid_q, clear_q};
      for (int i = 1; i < int'(LATENCY); i++) dly_d[i] = dly_q[i-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  dly_q <= '{default: '0};
      else if (cke)  dly_q <= dly_d;
    end

    assign {exp_c, chk_valid_c, chk_clear_c} = dly_q[LATENCY-1];
  end

  always_comb begin
    err_d = err_q;
    if (start_acc_c)
      err_d = '0;
    else if (chk_valid_c && !chk_clear_c && (m_data != exp_c) && (err_q != 16'hFFFF))
      err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  err_q <= '0;
    else if (cke)  err_q <= err_d;
  end

  assign err_count = err_q;
`else
  logic unused_c;
  assign unused_c  = m_data ^ start_acc_c;
  assign err_count = 16'h0;
`endif

endmodule
